// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset control unit: decodes the latched instruction and
// sequences fetch/decode/execute/memory/writeback, one state per clock.
module mc_ctrl_fsm #(
  parameter logic [4:0] RST_STATE = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [3:0]  ALU_operation,
  output logic [1:0]  MDRSrc,
  output logic [1:0]  Data_sel,
  output logic        ov_exc,
  output logic        illegal_inst,
  output logic [4:0]  state_out
);

  localparam logic [4:0] S_IF = 5'd0,  S_ID = 5'd1,  S_EX_R = 5'd2,  S_WB_R = 5'd3,
                         S_EX_I = 5'd4, S_WB_I = 5'd5, S_MEM_ADDR = 5'd6, S_MEM_RD = 5'd7,
                         S_MEM_WB = 5'd8, S_MEM_WR = 5'd9, S_BR = 5'd10, S_LUI = 5'd11,
                         S_J = 5'd12, S_JAL = 5'd13, S_JR = 5'd14;

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100,
                         ALU_XOR = 4'b0011;

  localparam logic [1:0] SZ_WORD = 2'd0, SZ_BYTE = 2'd1, SZ_HALF = 2'd2;

  logic [4:0] state, state_nx;
  logic [3:0] alu_q;
  logic [1:0] size_q;
  logic       load_q, beq_q, ovchk_q, ov_q;

  logic [5:0] op, fn;
  logic [4:0] dec_state;
  logic [3:0] dec_alu;
  logic [1:0] dec_size;
  logic       dec_load, dec_beq, dec_ovchk, dec_valid;

  // The FSM only looks at opcode/funct; branch resolution on zero happens in the data path.
  logic unused_inputs;
  assign unused_inputs = ^{Inst_in[25:6], zero};

  assign op = Inst_in[31:26];
  assign fn = Inst_in[5:0];

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    dec_state = S_IF;
    dec_alu   = ALU_ADD;
    dec_size  = SZ_WORD;
    dec_load  = 1'b0;
    dec_beq   = 1'b0;
    dec_ovchk = 1'b0;
    dec_valid = 1'b1;
    case (op)
      6'h00: begin
        dec_state = S_EX_R;
        case (fn)
          6'h20: dec_ovchk = 1'b1;
          6'h21: ;
          6'h22: begin dec_alu = ALU_SUB; dec_ovchk = 1'b1; end
          6'h23: dec_alu = ALU_SUB;
          6'h24: dec_alu = ALU_AND;
          6'h25: dec_alu = ALU_OR;
          6'h26: dec_alu = ALU_XOR;
          6'h27: dec_alu = ALU_NOR;
          6'h2a: dec_alu = ALU_SLT;
          6'h08: dec_state = S_JR;
          default: begin dec_state = S_IF; dec_valid = 1'b0; end
        endcase
      end
      6'h08: begin dec_state = S_EX_I; dec_ovchk = 1'b1; end
      6'h0c: begin dec_state = S_EX_I; dec_alu = ALU_AND; end
      6'h0d: begin dec_state = S_EX_I; dec_alu = ALU_OR;  end
      6'h0e: begin dec_state = S_EX_I; dec_alu = ALU_XOR; end
      6'h0a: begin dec_state = S_EX_I; dec_alu = ALU_SLT; end
      6'h23: begin dec_state = S_MEM_ADDR; dec_load = 1'b1; end
      6'h20: begin dec_state = S_MEM_ADDR; dec_load = 1'b1; dec_size = SZ_BYTE; end
      6'h21: begin dec_state = S_MEM_ADDR; dec_load = 1'b1; dec_size = SZ_HALF; end
      6'h2b: dec_state = S_MEM_ADDR;
      6'h28: begin dec_state = S_MEM_ADDR; dec_size = SZ_BYTE; end
      6'h29: begin dec_state = S_MEM_ADDR; dec_size = SZ_HALF; end
      6'h04: begin dec_state = S_BR; dec_beq = 1'b1; end
      6'h05: dec_state = S_BR;
      6'h0f: dec_state = S_LUI;
      6'h02: dec_state = S_J;
      6'h03: dec_state = S_JAL;
      default: dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = S_IF;
    case (state)
      S_IF:       state_nx = MIO_ready ? S_ID : S_IF;
      S_ID:       state_nx = dec_state;
      S_EX_R:     state_nx = S_WB_R;
      S_EX_I:     state_nx = S_WB_I;
      S_MEM_ADDR: state_nx = (!load_q && size_q == SZ_WORD) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_nx = !MIO_ready ? S_MEM_RD : (load_q ? S_MEM_WB : S_MEM_WR);
      S_MEM_WR:   state_nx = MIO_ready ? S_IF : S_MEM_WR;
      default:    state_nx = S_IF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RST_STATE;
      alu_q   <= ALU_AND;
      size_q  <= SZ_WORD;
      load_q  <= 1'b0;
      beq_q   <= 1'b0;
      ovchk_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_ID) begin
        alu_q   <= dec_alu;
        size_q  <= dec_size;
        load_q  <= dec_load;
        beq_q   <= dec_beq;
        ovchk_q <= dec_ovchk;
        ov_q    <= 1'b0;
      end
      if (state == S_EX_R || state == S_EX_I)
        ov_q <= overflow & ovchk_q;
    end
  end

  always_comb begin
    MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
    RegDst = 2'd0; RegWrite = 1'b0; MemtoReg = 2'd0;
    ALUSrcA = 2'd0; ALUSrcB = 2'd0; PCSource = 2'd0;
    PCWrite = 1'b0; PCWriteCond = 1'b0; Branch = 1'b0;
    ALU_operation = ALU_AND; MDRSrc = 2'd0; Data_sel = 2'd0; ov_exc = 1'b0;
    case (state)
      S_IF: begin
        MemRead = 1'b1; IRWrite = 1'b1; ALUSrcB = 2'd1;
        ALU_operation = ALU_ADD; PCWrite = 1'b1;
      end
      S_ID:       begin ALUSrcB = 2'd3; ALU_operation = ALU_ADD; end
      S_EX_R:     begin ALUSrcA = 2'd1; ALU_operation = alu_q; end
      S_WB_R:     begin RegDst = 2'd1; RegWrite = !ov_q; ov_exc = ov_q; end
      S_EX_I:     begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; ALU_operation = alu_q; end
      S_WB_I:     begin RegWrite = !ov_q; ov_exc = ov_q; end
      S_MEM_ADDR: begin ALUSrcA = 2'd1; ALUSrcB = 2'd2; ALU_operation = ALU_ADD; end
      S_MEM_RD:   begin MemRead = 1'b1; IorD = 1'b1; end
      S_MEM_WB:   begin RegWrite = 1'b1; MemtoReg = 2'd1; MDRSrc = size_q; end
      S_MEM_WR:   begin MemWrite = 1'b1; IorD = 1'b1; Data_sel = size_q; end
      S_BR: begin
        ALUSrcA = 2'd1; ALU_operation = ALU_SUB; PCWriteCond = 1'b1;
        PCSource = 2'd1; Branch = beq_q;
      end
      S_LUI:      begin RegWrite = 1'b1; MemtoReg = 2'd2; end
      S_J:        begin PCSource = 2'd2; PCWrite = 1'b1; end
      S_JAL: begin
        PCSource = 2'd2; PCWrite = 1'b1; RegWrite = 1'b1;
        RegDst = 2'd2; MemtoReg = 2'd3;
      end
      S_JR:       begin ALUSrcA = 2'd1; ALU_operation = ALU_OR; PCWrite = 1'b1; end
      default: ;
    endcase
    illegal_inst = (state == S_ID) && !dec_valid;
    // An aborting reset must not let the interrupted instruction commit anything.
    if (reset) begin
      RegWrite = 1'b0; MemWrite = 1'b0; PCWrite = 1'b0; PCWriteCond = 1'b0;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed vector table, reset-abort sequences, and
// random instruction streams checked against a path-based reference model.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MIO_ready = 1'b1;
  logic [31:0] Inst_in = '0;
  logic        zero = 1'b0;
  logic        overflow = 1'b0;
  logic        MemRead, MemWrite, IorD, IRWrite, RegWrite;
  logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, MDRSrc, Data_sel;
  logic        PCWrite, PCWriteCond, Branch, ov_exc, illegal_inst;
  logic [3:0]  ALU_operation;
  logic [4:0]  state_out;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .Inst_in(Inst_in),
    .zero(zero), .overflow(overflow), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .ALU_operation(ALU_operation), .MDRSrc(MDRSrc), .Data_sel(Data_sel),
    .ov_exc(ov_exc), .illegal_inst(illegal_inst), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] st;
    logic       mem_read, mem_write, iord, ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] mem_to_reg, src_a, src_b, pc_src;
    logic       pc_write, pc_write_cond, branch;
    logic [3:0] alu;
    logic [1:0] mdr_src, data_sel;
    logic       ov, ill;
  } full_t;

  typedef struct packed {
    logic [4:0] st;
    logic       rw, mw, pw, pwc, br, ovx, ill;
    logic [1:0] rd, m2r, ds, pcs;
    logic [3:0] alu;
  } out_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        mio, ovf, zr;
    out_t        exp;
  } vec_t;

  typedef enum logic [3:0] {
    K_RALU, K_IALU, K_LOAD, K_SW, K_SUBW, K_BR, K_LUI, K_J, K_JAL, K_JR, K_ILL
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [3:0] alu;
    logic       ovchk;
    logic [1:0] size;
    logic       beq;
  } info_t;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] I_ADD  = 32'h0022_1820, I_SB   = 32'hA022_0001,
                          I_SW   = 32'hAC22_0000, I_BEQ  = 32'h1022_0004,
                          I_BNE  = 32'h1422_0004, I_ADDI = 32'h2022_0005,
                          I_JAL  = 32'h0C00_0040, I_ILL  = 32'hFC00_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: inputs change on the falling edge, outputs are checked 1 ns later.
  task automatic drive(input logic [31:0] inst, input logic mio, ovf, zr, rst);
    @(negedge clk);
    Inst_in = inst; MIO_ready = mio; overflow = ovf; zero = zr; reset = rst;
    #1;
  endtask

  task automatic reset_seq();
    drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic full_t sample();
    full_t a;
    a.st = state_out; a.mem_read = MemRead; a.mem_write = MemWrite; a.iord = IorD;
    a.ir_write = IRWrite; a.reg_dst = RegDst; a.reg_write = RegWrite;
    a.mem_to_reg = MemtoReg; a.src_a = ALUSrcA; a.src_b = ALUSrcB; a.pc_src = PCSource;
    a.pc_write = PCWrite; a.pc_write_cond = PCWriteCond; a.branch = Branch;
    a.alu = ALU_operation; a.mdr_src = MDRSrc; a.data_sel = Data_sel;
    a.ov = ov_exc; a.ill = illegal_inst;
    return a;
  endfunction

  function automatic out_t to_out(full_t f);
    out_t o;
    o.st = f.st; o.rw = f.reg_write; o.mw = f.mem_write; o.pw = f.pc_write;
    o.pwc = f.pc_write_cond; o.br = f.branch; o.ovx = f.ov; o.ill = f.ill;
    o.rd = f.reg_dst; o.m2r = f.mem_to_reg; o.ds = f.data_sel; o.pcs = f.pc_src;
    o.alu = f.alu;
    return o;
  endfunction

  function automatic vec_t mk(logic [31:0] inst, int mio, int ovf, int zr, int st,
                              int rw, int mw, int pw, int pwc, int br, int ovx, int ill,
                              int rd, int m2r, int ds, int pcs, int alu);
    vec_t v;
    v.inst = inst; v.mio = 1'(mio); v.ovf = 1'(ovf); v.zr = 1'(zr);
    v.exp.st = 5'(st); v.exp.rw = 1'(rw); v.exp.mw = 1'(mw); v.exp.pw = 1'(pw);
    v.exp.pwc = 1'(pwc); v.exp.br = 1'(br); v.exp.ovx = 1'(ovx); v.exp.ill = 1'(ill);
    v.exp.rd = 2'(rd); v.exp.m2r = 2'(m2r); v.exp.ds = 2'(ds); v.exp.pcs = 2'(pcs);
    v.exp.alu = 4'(alu);
    return v;
  endfunction

  // Instruction classes straight from the opcode/funct table.
  function automatic info_t classify(logic [31:0] inst);
    info_t i;
    i = '0; i.kind = K_ILL; i.alu = 4'b0010;
    case (inst[31:26])
      6'h00: begin
        i.kind = K_RALU;
        case (inst[5:0])
          6'h20: i.ovchk = 1'b1;
          6'h21: ;
          6'h22: begin i.alu = 4'b0110; i.ovchk = 1'b1; end
          6'h23: i.alu = 4'b0110;
          6'h24: i.alu = 4'b0000;
          6'h25: i.alu = 4'b0001;
          6'h26: i.alu = 4'b0011;
          6'h27: i.alu = 4'b1100;
          6'h2a: i.alu = 4'b0111;
          6'h08: i.kind = K_JR;
          default: i.kind = K_ILL;
        endcase
      end
      6'h08: begin i.kind = K_IALU; i.ovchk = 1'b1; end
      6'h0c: begin i.kind = K_IALU; i.alu = 4'b0000; end
      6'h0d: begin i.kind = K_IALU; i.alu = 4'b0001; end
      6'h0e: begin i.kind = K_IALU; i.alu = 4'b0011; end
      6'h0a: begin i.kind = K_IALU; i.alu = 4'b0111; end
      6'h23: i.kind = K_LOAD;
      6'h20: begin i.kind = K_LOAD; i.size = 2'd1; end
      6'h21: begin i.kind = K_LOAD; i.size = 2'd2; end
      6'h2b: i.kind = K_SW;
      6'h28: begin i.kind = K_SUBW; i.size = 2'd1; end
      6'h29: begin i.kind = K_SUBW; i.size = 2'd2; end
      6'h04: begin i.kind = K_BR; i.beq = 1'b1; end
      6'h05: i.kind = K_BR;
      6'h0f: i.kind = K_LUI;
      6'h02: i.kind = K_J;
      6'h03: i.kind = K_JAL;
      default: i.kind = K_ILL;
    endcase
    return i;
  endfunction

  // Control word the specification requires in each state.
  function automatic full_t exp_full(int st, info_t inf, logic ovf);
    full_t e;
    e = '0; e.st = 5'(st);
    case (st)
      0:  begin e.mem_read = 1; e.ir_write = 1; e.src_b = 1; e.alu = 4'b0010; e.pc_write = 1; end
      1:  begin e.src_b = 3; e.alu = 4'b0010; e.ill = (inf.kind == K_ILL); end
      2:  begin e.src_a = 1; e.alu = inf.alu; end
      3:  begin e.reg_dst = 1; e.reg_write = !ovf; e.ov = ovf; end
      4:  begin e.src_a = 1; e.src_b = 2; e.alu = inf.alu; end
      5:  begin e.reg_write = !ovf; e.ov = ovf; end
      6:  begin e.src_a = 1; e.src_b = 2; e.alu = 4'b0010; end
      7:  begin e.mem_read = 1; e.iord = 1; end
      8:  begin e.reg_write = 1; e.mem_to_reg = 1; e.mdr_src = inf.size; end
      9:  begin e.mem_write = 1; e.iord = 1; e.data_sel = inf.size; end
      10: begin e.src_a = 1; e.alu = 4'b0110; e.pc_write_cond = 1; e.pc_src = 1; e.branch = inf.beq; end
      11: begin e.reg_write = 1; e.mem_to_reg = 2; end
      12: begin e.pc_src = 2; e.pc_write = 1; end
      13: begin e.pc_src = 2; e.pc_write = 1; e.reg_write = 1; e.reg_dst = 2; e.mem_to_reg = 3; end
      14: begin e.src_a = 1; e.alu = 4'b0001; e.pc_write = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [5:0]  op, fn;
    int sel;
    r = $urandom; sel = $urandom_range(0, 28); op = 6'h00; fn = 6'h20;
    case (sel)
      0: fn = 6'h20;  1: fn = 6'h21;  2: fn = 6'h22;  3: fn = 6'h23;  4: fn = 6'h24;
      5: fn = 6'h25;  6: fn = 6'h26;  7: fn = 6'h27;  8: fn = 6'h2a;  9: fn = 6'h08;
      10: op = 6'h08; 11: op = 6'h0c; 12: op = 6'h0d; 13: op = 6'h0e; 14: op = 6'h0a;
      15: op = 6'h23; 16: op = 6'h20; 17: op = 6'h21; 18: op = 6'h2b; 19: op = 6'h28;
      20: op = 6'h29; 21: op = 6'h04; 22: op = 6'h05; 23: op = 6'h0f; 24: op = 6'h02;
      25: op = 6'h03; 26: op = 6'h3f; 27: fn = 6'h3f; default: op = 6'h09;
    endcase
    return (op == 6'h00) ? {op, r[25:6], fn} : {op, r[25:0]};
  endfunction

  vec_t vt[$];

  initial begin
    // inst, mio, ovf, zero | state, rw, mw, pw, pwc, br, ovx, ill, regdst, memtoreg, data_sel, pcsrc, alu
    vt.push_back(mk(I_ADD, 1,0,0, 0,  0,0,1,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_ADD, 1,0,0, 1,  0,0,0,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_ADD, 1,0,0, 2,  0,0,0,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_ADD, 1,0,0, 3,  1,0,0,0,0,0,0, 1,0,0,0, 0));
    vt.push_back(mk(I_SB,  1,0,0, 0,  0,0,1,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_SB,  1,0,0, 1,  0,0,0,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_SB,  1,1,0, 6,  0,0,0,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_SB,  0,0,0, 7,  0,0,0,0,0,0,0, 0,0,0,0, 0));
    vt.push_back(mk(I_SB,  0,0,0, 7,  0,0,0,0,0,0,0, 0,0,0,0, 0));
    vt.push_back(mk(I_SB,  1,0,0, 7,  0,0,0,0,0,0,0, 0,0,0,0, 0));
    vt.push_back(mk(I_SB,  1,0,0, 9,  0,1,0,0,0,0,0, 0,0,1,0, 0));
    vt.push_back(mk(I_BEQ, 1,0,1, 0,  0,0,1,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_BEQ, 1,0,1, 1,  0,0,0,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_BEQ, 1,0,1, 10, 0,0,0,1,1,0,0, 0,0,0,1, 6));
    vt.push_back(mk(I_BNE, 1,0,1, 0,  0,0,1,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_BNE, 1,0,1, 1,  0,0,0,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_BNE, 1,0,1, 10, 0,0,0,1,0,0,0, 0,0,0,1, 6));
    vt.push_back(mk(I_ADDI,1,0,0, 0,  0,0,1,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_ADDI,1,0,0, 1,  0,0,0,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_ADDI,1,1,0, 4,  0,0,0,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_ADDI,1,0,0, 5,  0,0,0,0,0,1,0, 0,0,0,0, 0));
    vt.push_back(mk(I_JAL, 1,0,0, 0,  0,0,1,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_JAL, 1,0,0, 1,  0,0,0,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_JAL, 1,0,0, 13, 1,0,1,0,0,0,0, 2,3,0,2, 0));
    vt.push_back(mk(I_ILL, 1,0,0, 0,  0,0,1,0,0,0,0, 0,0,0,0, 2));
    vt.push_back(mk(I_ILL, 1,0,0, 1,  0,0,0,0,0,0,1, 0,0,0,0, 2));
    vt.push_back(mk(I_ADD, 1,0,0, 0,  0,0,1,0,0,0,0, 0,0,0,0, 2));

    // Reset state: IF with every write strobe held off while reset is high.
    drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("reset_state", 64'(state_out), 64'd0);
    check("reset_strobes", 64'({RegWrite, MemWrite, PCWrite, PCWriteCond}), 64'd0);
    drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    foreach (vt[k]) begin
      drive(vt[k].inst, vt[k].mio, vt[k].ovf, vt[k].zr, 1'b0);
      check($sformatf("vec%0d", k), 64'(to_out(sample())), 64'(vt[k].exp));
    end

    // Reset while waiting in MEM_RD: back to IF, nothing written.
    reset_seq();
    drive(I_SB, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(I_SB, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(I_SB, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(I_SB, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_in_memrd_state", 64'(state_out), 64'd7);
    check("rst_in_memrd_nowrite", 64'({MemWrite, RegWrite, PCWrite}), 64'd0);
    drive(I_SB, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_in_memrd_next", 64'({state_out, MemWrite}), 64'd0);

    // Reset while in MEM_WR: the store strobe must be suppressed.
    reset_seq();
    drive(I_SW, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(I_SW, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(I_SW, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(I_SW, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_in_memwr", 64'({state_out, MemWrite}), 64'({5'd9, 1'b0}));
    drive(I_SW, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_in_memwr_next", 64'(state_out), 64'd0);

    // Reset while in JAL: neither $31 nor PC may be written.
    reset_seq();
    drive(I_JAL, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(I_JAL, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(I_JAL, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_in_jal", 64'({state_out, RegWrite, PCWrite}), 64'({5'd13, 2'b00}));
    drive(I_JAL, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_in_jal_next", 64'(state_out), 64'd0);

    // Random instruction stream against the path model.
    reset_seq();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] inst;
      info_t       inf;
      int          path[5];
      int          plen, idx;
      logic        ov_flag, mio, ovf;
      inst = rand_inst();
      inf = classify(inst);
      path = '{0, 1, 0, 0, 0};
      case (inf.kind)
        K_RALU:  begin path = '{0, 1, 2, 3, 0};  plen = 4; end
        K_IALU:  begin path = '{0, 1, 4, 5, 0};  plen = 4; end
        K_LOAD:  begin path = '{0, 1, 6, 7, 8};  plen = 5; end
        K_SW:    begin path = '{0, 1, 6, 9, 0};  plen = 4; end
        K_SUBW:  begin path = '{0, 1, 6, 7, 9};  plen = 5; end
        K_BR:    begin path[2] = 10; plen = 3; end
        K_LUI:   begin path[2] = 11; plen = 3; end
        K_J:     begin path[2] = 12; plen = 3; end
        K_JAL:   begin path[2] = 13; plen = 3; end
        K_JR:    begin path[2] = 14; plen = 3; end
        default: plen = 2;
      endcase
      idx = 0; ov_flag = 1'b0;
      while (idx < plen) begin
        int st;
        st  = path[idx];
        mio = ($urandom_range(0, 3) != 0);
        ovf = 1'($urandom);
        drive(inst, mio, ovf, 1'($urandom), 1'b0);
        check($sformatf("rand%0d_op%02h_st%0d", n, inst[31:26], st),
              64'(sample()), 64'(exp_full(st, inf, ov_flag)));
        if (st == 2 || st == 4) ov_flag = ovf & inf.ovchk;
        if (!((st == 0 || st == 7 || st == 9) && !mio)) idx++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS-subset control unit that drives every control input of the CPU data path.
- Decodes the latched instruction word and sequences IF/ID/EX/MEM/WB one state per cycle.
- Stalls on memory wait and reports overflow and illegal-opcode events.
- Sits directly upstream of the data path: its outputs connect 1:1 to the data path's control inputs; it consumes the data path's IR_out, zero and overflow.

Parameters:
RST_STATE, 5'd0, state code entered on reset (IF).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
MIO_ready  in  1  memory ready; 0 holds FSM in memory states
Inst_in  in  32  instruction register from data path (IR_out)
zero  in  1  ALU zero flag
overflow  in  1  ALU signed overflow flag
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IorD  out  1  0=PC address, 1=ALU_out address
IRWrite  out  1  instruction fetch cycle
RegDst  out  2  0=rt, 1=rd, 2=$31
RegWrite  out  1  register file write enable
MemtoReg  out  2  0=ALU_out, 1=MDR, 2={imm,16'b0}, 3=PC
ALUSrcA  out  2  0=PC, 1=rs, 2=imm32, 3=0
ALUSrcB  out  2  0=rt, 1=4, 2=imm32, 3=imm32<<2
PCSource  out  2  0=ALU result, 1=ALU_out, 2=jump target
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  conditional PC write
Branch  out  1  1=take on zero (beq), 0=take on ~zero (bne)
ALU_operation  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 0011 XOR
MDRSrc  out  2  0=word, 1=byte, 2=half
Data_sel  out  2  0=word, 1=sb merge, 2=sh merge
ov_exc  out  1  one-cycle pulse: overflow, writeback suppressed
illegal_inst  out  1  one-cycle pulse: undecoded opcode/funct
state_out  out  5  current state code, debug

Behaviour:
- Reset (sync, high): state=IF. All outputs 0 except the IF-state values below. Reset mid-instruction aborts the instruction; no RegWrite, MemWrite or PC write occurs in that cycle.
- All outputs are Moore: a combinational decode of the state register plus the registered opcode/funct class. Any output not listed for a state is 0.
- IF(0):
  - MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PCWrite=1.
  - If MIO_ready=0, stay in IF.
  - Otherwise go to ID.
- ID(1):
  - ALUSrcA=0, ALUSrcB=3, ADD, which precomputes the branch target into ALU_out.
  - Decode and register the instruction class.
  - Next state: R-ALU→EX_R; addi/andi/ori/xori/slti→EX_I; lw/lb/lh/sw/sb/sh→MEM_ADDR; beq/bne→BR; lui→LUI; j→J; jal→JAL; jr→JR.
  - Anything else: illegal_inst=1 for this cycle, next state IF.
- EX_R(2): ALUSrcA=1, ALUSrcB=0, op from funct: add/addu→ADD, sub/subu→SUB, and, or, xor, nor, slt. Register the overflow flag only for add/sub. Next state WB_R.
- WB_R(3): RegDst=1, MemtoReg=0, then IF.
  - RegWrite=1 unless the overflow flag is set.
  - If the overflow flag is set: RegWrite=0 and ov_exc=1.
- EX_I(4): ALUSrcA=1, ALUSrcB=2, op from opcode. Overflow is flagged for addi only. Next state WB_I.
- WB_I(5): RegDst=0, MemtoReg=0; overflow handling identical to WB_R. Next state IF.
- MEM_ADDR(6): ALUSrcA=1, ALUSrcB=2, ADD.
  - Loads, sb and sh go to MEM_RD.
  - sw goes to MEM_WR.
- MEM_RD(7): MemRead=1, IorD=1; wait while MIO_ready=0.
  - Loads go to MEM_WB.
  - sb/sh go to MEM_WR (read-modify-write).
- MEM_WB(8): RegWrite=1, RegDst=0, MemtoReg=1, MDRSrc = 0/1/2 for lw/lb/lh. Next state IF.
- MEM_WR(9): MemWrite=1, IorD=1, Data_sel = 0/1/2 for sw/sb/sh; wait while MIO_ready=0. Next state IF.
- BR(10): ALUSrcA=1, ALUSrcB=0, SUB, PCWriteCond=1, PCSource=1, Branch=1 for beq and 0 for bne. Next state IF.
- LUI(11): RegWrite=1, RegDst=0, MemtoReg=2. Next state IF.
- J(12): PCSource=2, PCWrite=1. Next state IF.
- JAL(13): PCSource=2, PCWrite=1, RegWrite=1, RegDst=2, MemtoReg=3. $31 receives the pre-update PC (PC+4) on the same edge. Next state IF.
- JR(14): ALUSrcA=1, ALUSrcB=0, OR, PCSource=0, PCWrite=1; the PC is loaded with rs|rt (rt=$0 by encoding). Next state IF.
- Unused state codes: next state IF, all strobes 0.
- Cycle counts: R/I-ALU 4; lw/lb/lh 5; sw 4; sb/sh 5; beq/bne 3; j/jal/jr/lui 3. Add one cycle per MIO_ready=0 cycle in IF, MEM_RD and MEM_WR.
- Simultaneous events: overflow in a non-add/sub state is ignored. MIO_ready has no effect in non-memory states.

Test Plan:
- Reset then `add $3,$1,$2` with MIO_ready=1 → states 0,1,2,3,0; RegWrite=1, RegDst=1 in cycle 4 only; ALU_operation=0010 in EX_R.
- `sb $2,1($1)` with MIO_ready low for 2 cycles in MEM_RD → states 0,1,6,7,7,7,9,0; MemWrite=1 with Data_sel=1 only in state 9.
- `beq` with zero=1, then `bne` with zero=1 → PCWriteCond=1 both times; Branch=1 then Branch=0.
- `addi` with overflow=1 in EX_I → WB_I shows RegWrite=0, ov_exc=1 for one cycle.
- `jal 0x100` → in state 13: RegDst=2, MemtoReg=3, RegWrite=1, PCWrite=1, PCSource=2 in the same cycle.
- Opcode 6'b111111 → illegal_inst pulse in ID, next state 0. Reset asserted during state 7 → state 0 next cycle, no MemWrite.
